// File: rtl/ram_stream_reader_d1.sv
// ram_stream_reader_d1: issues consecutive RAM reads and streams the words out with backpressure
module ram_stream_reader_d1 #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [AWIDTH-1:0] i_start_addr,
  input  logic [AWIDTH:0]   i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH-1:0] o_ram_addr,
  output logic              o_ram_we,
  input  logic [DWIDTH-1:0] i_ram_dout,
  output logic [DWIDTH-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_addr, r_last_addr;
  logic [AWIDTH:0] r_icnt, r_dcnt;
  logic [DWIDTH-1:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_count;
  logic r_inflight, r_done;
  logic w_start, w_issue, w_pop, w_last_pop;
  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  assign o_ram_we = 1'b0;
  assign o_ram_addr = w_issue ? r_addr : r_last_addr;
  assign o_m_valid = r_count != 3'd0;
  assign o_m_data = r_fifo[r_rp];
  assign o_m_last = o_m_valid && r_dcnt == (AWIDTH+1)'(1);
  // issue credit, handshake and next-state decisions; credits freed by a pop count from the next cycle
  always_comb begin
    w_start = r_state == IDLE && i_start;
    w_issue = r_state == RUN && r_icnt != '0 && (r_count + {2'b0, r_inflight}) < 3'd4;
    w_pop = o_m_valid && i_m_ready;
    w_last_pop = w_pop && r_dcnt == (AWIDTH+1)'(1);
    w_state_nxt = r_state;
    if (w_start && i_length != '0)
      w_state_nxt = RUN;
    else if (w_last_pop)
      w_state_nxt = IDLE;
    else if (w_issue && r_icnt == (AWIDTH+1)'(1))
      w_state_nxt = DRAIN;
  end
  // state, counters, inflight flag and FIFO pointers
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_done <= 1'b0;
      r_addr <= '0;
      r_last_addr <= '0;
      r_icnt <= '0;
      r_dcnt <= '0;
      r_inflight <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done <= (w_start && i_length == '0) || w_last_pop;
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr <= i_start_addr;
        r_icnt <= i_length;
        r_dcnt <= i_length;
      end else begin
        if (w_issue) begin
          r_addr <= r_addr + 1'b1;
          r_icnt <= r_icnt - 1'b1;
          r_last_addr <= r_addr;
        end
        if (w_pop)
          r_dcnt <= r_dcnt - 1'b1;
      end
      if (r_inflight)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_count <= r_count + {2'b0, r_inflight} - {2'b0, w_pop};
    end
  end
  // capture the RAM word one cycle after its address was issued
  always_ff @(posedge i_clock) begin
    if (r_inflight)
      r_fifo[r_wp] <= i_ram_dout;
  end
endmodule

// File: tb/tb_ram_stream_reader_d1.sv
// tb_ram_stream_reader_d1: randomized stream checks against a queue-based model of the read run
module tb_ram_stream_reader_d1;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic m_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0] length = '0;
  logic busy, done, ram_we, m_valid, m_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout, m_data;
  logic [DW-1:0] mem [DEPTH];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // synchronous-read RAM model
  always @(posedge clk) ram_dout <= mem[ram_addr];

  ram_stream_reader_d1 #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_start_addr(start_addr),
    .i_length(length), .o_busy(busy), .o_done(done), .o_ram_addr(ram_addr),
    .o_ram_we(ram_we), .i_ram_dout(ram_dout), .o_m_data(m_data), .o_m_valid(m_valid),
    .i_m_ready(m_ready), .o_m_last(m_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int k = 0; k < DEPTH; k++) mem[k] = rnd ? $urandom : DW'(k + 100);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || ram_addr !== '0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b valid=%b last=%b addr=%0d we=%b, want all 0", busy, done, m_valid, m_last, ram_addr, ram_we);
    end
    rst_n = 1'b1;
    tick;
  endtask

  // one run: sa/len, ready probability, ready held low for 'hold' cycles,
  // 'timed' checks exact latency/addresses with ready=1, 'poke' asserts start mid-run
  task automatic run_stream(input string name, input int sa, input int len, input int pct,
                            input int hold, input bit timed, input bit poke);
    logic [DW-1:0] exp_q [$];
    int got = 0;
    int last_hs = -1;
    int exp_idx;
    bit ok_done = 1'b0;
    bit rdy;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);
    start = 1'b1;
    start_addr = AW'(sa);
    length = (AW+1)'(len);
    tick;
    start = 1'b0;
    start_addr = AW'($urandom);
    length = (AW+1)'($urandom);
    vectors++;
    if (busy !== (len != 0)) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want %b", name, busy, len != 0);
    end
    for (int idx = 0; idx < 400; idx++) begin
      if (done === 1'b1) begin
        exp_idx = (len == 0) ? 0 : last_hs + 1;
        vectors++;
        if (idx != exp_idx || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s done_timing: cycle %0d busy=%b, want cycle %0d busy=0", name, idx, busy, exp_idx);
        end
        ok_done = 1'b1;
        break;
      end
      start = poke && idx == 3;
      if (start) begin
        start_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(15, 1));
      end
      if (timed && idx < len) begin
        vectors++;
        if (ram_addr !== AW'((sa + idx) % DEPTH)) begin
          miscompares++;
          $display("FAIL %s ram_addr[%0d]: got %0d want %0d", name, idx, ram_addr, (sa + idx) % DEPTH);
        end
      end
      if (hold > 0 && idx == hold - 1) begin
        vectors++;
        if (ram_addr !== AW'((sa + 3) % DEPTH) || m_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL %s stall_issues: addr=%0d valid=%b, want addr=%0d valid=1", name, ram_addr, m_valid, (sa + 3) % DEPTH);
        end
      end
      if (m_last !== (m_valid && got == len - 1) || ram_we !== 1'b0 || (len == 0 && m_valid !== 1'b0)) begin
        vectors++;
        miscompares++;
        $display("FAIL %s flags[%0d]: last=%b valid=%b we=%b, want last only on word %0d, we=0", name, idx, m_last, m_valid, ram_we, len - 1);
      end
      rdy = idx >= hold && $urandom_range(99) < pct;
      m_ready = rdy;
      if (m_valid && rdy) begin
        vectors++;
        if (got >= len || m_data !== exp_q[got] || (timed && idx != 2 + got)) begin
          miscompares++;
          $display("FAIL %s word%0d: data=%0d at cycle %0d, want %0d at cycle %0d", name, got, m_data, idx,
                   (got < len) ? exp_q[got] : 0, 2 + got);
        end
        got++;
        if (got == len) last_hs = idx;
      end
      tick;
    end
    start = 1'b0;
    m_ready = 1'b0;
    vectors++;
    if (!ok_done || got != len) begin
      miscompares++;
      $display("FAIL %s completion: done_seen=%b words=%0d, want done_seen=1 words=%0d", name, ok_done, got, len);
    end
  endtask

  task automatic test_reset_mid;
    int got = 0;
    m_ready = 1'b1;
    start = 1'b1;
    start_addr = '0;
    length = (AW+1)'(8);
    tick;
    start = 1'b0;
    for (int idx = 0; idx < 20 && got < 2; idx++) begin
      if (m_valid) got++;
      tick;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b busy=%b done=%b addr=%0d, want 0 0 0 0", m_valid, busy, done, ram_addr);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      vectors++;
      if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet[%0d]: done=%b valid=%b busy=%b, want 0 0 0", i, done, m_valid, busy);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_random;
    fill_mem(1'b1);
    for (int r = 0; r < 8; r++)
      run_stream("random", int'($urandom_range(DEPTH - 1)), int'($urandom_range(15)), int'($urandom_range(100, 30)), 0, 1'b0, 1'b0);
  endtask

  initial begin
    fill_mem(1'b0);
    test_reset;
    run_stream("basic", 2, 4, 100, 0, 1'b1, 1'b0);
    run_stream("wrap", 6, 4, 100, 0, 1'b1, 1'b0);
    run_stream("backpressure", 0, 8, 100, 10, 1'b0, 1'b0);
    run_stream("random_ready", 5, 15, 50, 0, 1'b0, 1'b0);
    run_stream("zero_length", 3, 0, 100, 0, 1'b0, 1'b0);
    run_stream("ignore_start", 1, 8, 100, 0, 1'b1, 1'b1);
    run_stream("back_to_back", 7, 15, 100, 0, 1'b1, 1'b0);
    test_reset_mid;
    run_stream("after_reset", 4, 5, 100, 0, 1'b1, 1'b0);
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
